// File: rtl/imm_pkg.sv
// imm_pkg: mode encodings, FSM state type and default dimensions for the mask compositor.
package imm_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_KEY, MODE_AND, MODE_AVG} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_MASK_W = 160;
  localparam int DEF_MASK_H = 120;
  localparam int DEF_CH_BITS = 4;
endpackage

// File: rtl/mask_pixel_combine.sv
// mask_pixel_combine: combinational per-pixel blend of image and mask by mode and window flag.
module mask_pixel_combine
  import imm_pkg::*;
#(
  parameter int CH_BITS = DEF_CH_BITS
) (
  input  mode_t                  mode,
  input  logic                   in_window,
  input  logic [3*CH_BITS-1:0]   img,
  input  logic [3*CH_BITS-1:0]   mask,
  output logic [3*CH_BITS-1:0]   pixel
);
  logic [3*CH_BITS-1:0] avg;
  always_comb begin
    avg = '0;
    for (int i = 0; i < 3; i++)
      avg[i*CH_BITS +: CH_BITS] = CH_BITS'(({1'b0, img[i*CH_BITS +: CH_BITS]} + {1'b0, mask[i*CH_BITS +: CH_BITS]}) >> 1);
  end
  assign pixel = !in_window        ? img :
                 mode == MODE_KEY  ? (mask == '0 ? '0 : img) :
                 mode == MODE_AND  ? (img & mask) :
                 mode == MODE_AVG  ? avg : img;
endmodule

// File: rtl/mask_compositor.sv
// mask_compositor: raster-scans an image ROM, blends a mask ROM inside an offset window
// and streams the result to a frame buffer through a 3-stage stallable pipeline.
module mask_compositor
  import imm_pkg::*;
#(
  parameter  int IMG_W   = DEF_IMG_W,
  parameter  int IMG_H   = DEF_IMG_H,
  parameter  int MASK_W  = DEF_MASK_W,
  parameter  int MASK_H  = DEF_MASK_H,
  parameter  int CH_BITS = DEF_CH_BITS,
  localparam int RW  = $clog2(IMG_H),
  localparam int CW  = $clog2(IMG_W),
  localparam int MRW = $clog2(MASK_H),
  localparam int MCW = $clog2(MASK_W),
  localparam int PW  = 3*CH_BITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [RW-1:0]  mask_row_offset,
  input  logic [CW-1:0]  mask_col_offset,
  output logic           rom_en,
  output logic [RW-1:0]  img_row,
  output logic [CW-1:0]  img_col,
  input  logic [PW-1:0]  img_pixel,
  output logic [MRW-1:0] mask_row,
  output logic [MCW-1:0] mask_col,
  input  logic [PW-1:0]  mask_pixel,
  output logic           wr_en,
  output logic [RW-1:0]  wr_row,
  output logic [CW-1:0]  wr_col,
  output logic [PW-1:0]  wr_pixel,
  input  logic           wr_ready,
  output logic           busy,
  output logic           done
);
  state_t         state, nxt;
  mode_t          mode_q;
  logic [RW-1:0]  row_off, r1;
  logic [CW-1:0]  col_off, c1;
  logic [RW:0]    dr;
  logic [CW:0]    dc;
  logic           in_win, in1, v1, stall, last_col, last_row;
  logic [PW-1:0]  pix;

  assign stall    = wr_en & ~wr_ready;
  assign busy     = state == S_SCAN || state == S_DRAIN;
  assign done     = state == S_DONE;
  assign rom_en   = busy & ~stall;
  assign last_col = img_col == CW'(IMG_W-1);
  assign last_row = img_row == RW'(IMG_H-1);
  // one extra bit so a position above/left of the window reads as negative
  assign dr       = {1'b0, img_row} - {1'b0, row_off};
  assign dc       = {1'b0, img_col} - {1'b0, col_off};
  assign in_win   = !dr[RW] && dr < (RW+1)'(MASK_H) && !dc[CW] && dc < (CW+1)'(MASK_W);
  assign mask_row = in_win ? MRW'(dr) : '0;
  assign mask_col = in_win ? MCW'(dc) : '0;

  always_comb begin
    nxt = state == S_IDLE  ? (start ? S_SCAN : S_IDLE) :
          state == S_SCAN  ? (!stall && last_col && last_row ? S_DRAIN : S_SCAN) :
          state == S_DRAIN ? (!v1 && !stall ? S_DONE : S_DRAIN) : S_IDLE;
  end

  mask_pixel_combine #(.CH_BITS(CH_BITS)) u_combine (
    .mode(mode_q), .in_window(in1), .img(img_pixel), .mask(mask_pixel), .pixel(pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= MODE_PASS;
      row_off  <= '0;
      col_off  <= '0;
      img_row  <= '0;
      img_col  <= '0;
      v1       <= 1'b0;
      r1       <= '0;
      c1       <= '0;
      in1      <= 1'b0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_pixel <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        mode_q  <= mode_t'(mode);
        row_off <= mask_row_offset;
        col_off <= mask_col_offset;
        img_row <= '0;
        img_col <= '0;
      end else if (state == S_SCAN && !stall) begin
        img_col <= last_col ? '0 : img_col + 1'b1;
        if (last_col) img_row <= last_row ? '0 : img_row + 1'b1;
      end
      // ROM outputs hold while rom_en is low, so freezing these keeps data aligned
      if (!stall) begin
        v1    <= state == S_SCAN;
        r1    <= img_row;
        c1    <= img_col;
        in1   <= in_win;
        wr_en <= v1;
        if (v1) begin
          wr_row   <= r1;
          wr_col   <= c1;
          wr_pixel <= pix;
        end
      end
    end
  end
endmodule

// File: doc/mask_compositor.md
MASK_COMPOSITOR -- requirements
Module: mask_compositor

Interface
REQ-001 Parameter IMG_W, default 320: image columns.
REQ-002 Parameter IMG_H, default 240: image rows.
REQ-003 Parameter MASK_W, default 160: mask columns.
REQ-004 Parameter MASK_H, default 120: mask rows.
REQ-005 Parameter CH_BITS, default 4: bits per colour channel; pixel = 3*CH_BITS, {R,G,B} MSB-first.
REQ-006 Derived widths SHALL be: RW = clog2(IMG_H), CW = clog2(IMG_W), MRW = clog2(MASK_H), MCW = clog2(MASK_W), PW = 3*CH_BITS.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 start  in  1  one-cycle frame request.
REQ-011 mode  in  2  combine mode: 0 PASS, 1 KEY, 2 AND, 3 AVG.
REQ-012 mask_row_offset  in  RW, and mask_col_offset  in  CW: top-left of mask window.
REQ-013 rom_en  out  1  read enable shared by image and mask ROMs.
REQ-014 img_row  out  RW, img_col  out  CW, img_pixel  in  PW: image ROM port, synchronous, 1-cycle read latency.
REQ-015 mask_row  out  MRW, mask_col  out  MCW, mask_pixel  in  PW: mask ROM port, same timing.
REQ-016 wr_en  out  1, wr_row  out  RW, wr_col  out  CW, wr_pixel  out  PW: frame-buffer write port.
REQ-017 wr_ready  in  1  frame buffer accepts write when high.
REQ-018 busy  out  1; done  out  1 (one-cycle pulse).

Function
REQ-019 FSM states: IDLE, SCAN, DRAIN, DONE.
REQ-020 IDLE + start: latch mode and both offsets, clear counters, go to SCAN; start ignored in every other state.
REQ-021 SCAN: issue addresses in raster order, column fastest, (0,0) to (IMG_H-1, IMG_W-1), one per un-stalled cycle; after last address go to DRAIN.
REQ-022 DRAIN: no new addresses; leave when pipeline empty, go to DONE; DONE lasts one cycle, asserts done, returns to IDLE.
REQ-023 busy SHALL be high in SCAN and DRAIN, low in IDLE and DONE.
REQ-024 Pipeline: stage 0 address issue, stage 1 ROM data plus registered coordinates/in-window flag, stage 2 registered write outputs; address-to-wr_en latency 2 cycles when unstalled.
REQ-025 Stall = wr_en & ~wr_ready; during stall all counters, pipeline registers and ROM addresses hold, rom_en = 0, wr_* outputs unchanged.
REQ-026 rom_en = 1 in SCAN and DRAIN when not stalled, else 0.
REQ-027 In-window: (row - row_off) < MASK_H and (col - col_off) < MASK_W, subtractions in RW+1/CW+1 bits, negative result = outside.
REQ-028 mask_row/mask_col = in-window differences truncated to MRW/MCW; 0 when outside.
REQ-029 Outside window: wr_pixel = img_pixel for every mode.
REQ-030 Inside window: PASS = img; KEY = img if mask != 0 else 0; AND = img & mask; AVG = per channel (img + mask) >> 1 in CH_BITS+1 bits, truncated.
REQ-031 Offsets beyond image bounds: window partially or fully clipped, no error, out-of-image mask area never read.
REQ-032 Exactly IMG_W*IMG_H writes per frame, each accepted once; done asserted in the cycle after the last accepted write.

Reset
REQ-033 rst SHALL force IDLE, busy = 0, done = 0, wr_en = 0, rom_en = 0, all addresses, coordinates, wr_pixel, latched mode and offsets = 0.
REQ-034 rst mid-frame SHALL abandon the frame; no further writes until next start.

Structure
REQ-035 Shared package imm_pkg SHALL hold mode encodings, FSM state type and default dimension constants.
REQ-036 Per-pixel combine logic SHALL be sub-module mask_pixel_combine (combinational: mode, in_window, img, mask -> pixel).

Verification
REQ-037 IMG 8x4, MASK 2x2, offsets (1,2), mode PASS, wr_ready=1 -> 32 writes, raster order, wr_pixel = image, done 1 cycle after write 32.
REQ-038 Same, mode KEY, mask 0x000 at mask (0,0), image 0xFA5 -> write (1,2) = 0x000; (1,3) = image; all out-of-window = image.
REQ-039 Mode AVG, img 0xF00, mask 0x0F0 in window -> 0x770; mode AND img 0xFA5, mask 0x0F3 -> 0x0A1.
REQ-040 wr_ready low 3 cycles at write 5 -> wr_* held stable, no address advance, no duplicate or lost write, total 32.
REQ-041 Offsets (3,7) with MASK 2x2 -> only (3,7) in window; mask_row/col = (0,0) there, 0 elsewhere.
REQ-042 rst asserted at write 10, start reissued -> outputs at reset values immediately, new frame complete from (0,0); start during busy ignored.
